// File: rtl/cpu_types_pkg.sv
// Shared CPU types: datapath word and next-PC source encoding.
package cpu_types_pkg;

  localparam int WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  // Encoding matches {JReg, PcSrc} coming out of control_unit.
  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JR  = 2'b10,
    PC_J   = 2'b11
  } pcsel_t;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC computation: sequential, branch, register jump, absolute jump.
// All arithmetic wraps modulo 2^32.
module next_pc_logic
  import cpu_types_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [1:0]  pcsel,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] j_target;
  pcsel_t      sel;

  assign pc_plus4  = pc + 32'd4;
  // Sign-extended word offset, relative to the instruction after the branch.
  assign br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign br_target = pc_plus4 + br_offset;
  // Absolute jump stays inside the 256 MB region of the delay-slot PC.
  assign j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign sel       = pcsel_t'(pcsel);

  // Select the target according to the control_unit selector.
  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      PC_SEQ:  next_pc = pc_plus4;
      PC_BR:   next_pc = br_target;
      PC_JR:   next_pc = rs_data;
      PC_J:    next_pc = j_target;
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_request_unit.sv
// Fetch/request stage: owns the PC, issues imem/dmem requests, holds the current
// instruction for decode and pulses instr_done when an instruction retires.
//
// Handshake: a request (imemREN / dmemREN / dmemWEN) is held high continuously
// until the matching completion (ihit / dhit) is sampled at a rising CLK edge;
// a completion while its request is low is ignored. ihit has no effect in DATA,
// dhit has no effect in FETCH, so a simultaneous ihit & dhit in DATA acts as dhit only.
module pc_request_unit
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int          WORD_W  = 32
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic [31:0] imemload,
  input  logic        PcSrc,
  input  logic        JReg,
  input  logic        Halt,
  input  logic        dMemRe,
  input  logic        dMemWr,
  input  logic [31:0] rs_data,
  output logic [31:0] imemaddr,
  output logic        imemREN,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        instr_done,
  output logic        halt,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    DATA   = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, ir, npc_q;
  logic        dren_q, dwen_q;
  logic [31:0] next_pc;
  logic [31:0] pc_d;
  logic        pc_load;
  logic        capture;
  logic        imem_ren;
  logic        dmem_ren;
  logic        dmem_wen;
  logic        done;

  // In FETCH the instruction comes straight from imem so it can be decoded in the hit cycle.
  assign instr     = (state == FETCH) ? imemload : ir;
  assign imemaddr  = pc;
  assign halt      = (state == HALTED);
  assign state_dbg = state;

  // Gating with nRST keeps the fetch request and retire pulse low while reset is held.
  assign imemREN    = imem_ren & nRST;
  assign instr_done = done & nRST;
  assign dmemREN    = dmem_ren;
  assign dmemWEN    = dmem_wen;

  next_pc_logic u_next_pc (
    .pc       (pc),
    .instr    (instr),
    .rs_data  (rs_data),
    .pcsel    ({JReg, PcSrc}),
    .next_pc  (next_pc),
    .pc_plus4 (pc_plus4)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= FETCH;
    else       state <= state_next;
  end

  // Next-state decode and request/retire outputs.
  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    pc_d       = next_pc;
    capture    = 1'b0;
    imem_ren   = 1'b0;
    dmem_ren   = 1'b0;
    dmem_wen   = 1'b0;
    done       = 1'b0;
    case (state)
      FETCH: begin
        imem_ren = 1'b1;
        if (ihit) begin
          if (Halt) begin
            state_next = HALTED;
          end else if (dMemRe || dMemWr) begin
            state_next = DATA;
            capture    = 1'b1;
          end else begin
            pc_load = 1'b1;
            pc_d    = next_pc;
            done    = 1'b1;
          end
        end
      end
      DATA: begin
        dmem_ren = dren_q;
        dmem_wen = dwen_q;
        if (dhit) begin
          state_next = FETCH;
          pc_load    = 1'b1;
          pc_d       = npc_q;
          done       = 1'b1;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // PC, instruction register, deferred next PC and latched data-request kind.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc     <= PC_INIT;
      ir     <= '0;
      npc_q  <= '0;
      dren_q <= 1'b0;
      dwen_q <= 1'b0;
    end else begin
      if (pc_load) pc <= pc_d;
      if (capture) begin
        ir     <= imemload;
        npc_q  <= next_pc;
        dren_q <= dMemRe;
        dwen_q <= dMemWr;
      end
    end
  end

endmodule
